alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/calc_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 31 +++
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and defaults for the ALU request arbiter
package calc_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with one-hot grant
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // ptr names the requester preferred when both are asking
  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  assign grant_idx = grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant_idx;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters, one operation in flight
module alu_arbiter
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0][DATA_WIDTH-1:0] i_req_a,
  input  logic [1:0][DATA_WIDTH-1:0] i_req_b,
  input  logic [1:0][1:0]            i_req_op,
  input  logic [1:0]                 i_req_signed,
  input  logic [1:0]                 i_req_valid,
  output logic [1:0]                 o_req_ready,
  output logic [DATA_WIDTH-1:0]      o_rsp_result,
  output logic                       o_rsp_error,
  output logic [1:0]                 o_rsp_valid,
  input  logic [1:0]                 i_rsp_ready,
  output logic [DATA_WIDTH-1:0]      o_alu_input_a,
  output logic [DATA_WIDTH-1:0]      o_alu_input_b,
  output logic [1:0]                 o_alu_input_op,
  output logic                       o_alu_input_signed,
  output logic                       o_alu_input_valid,
  input  logic                       i_alu_input_ready,
  input  logic [DATA_WIDTH-1:0]      i_alu_result,
  input  logic                       i_alu_error,
  input  logic                       i_alu_result_valid,
  output logic                       o_alu_result_ready
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  arb_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
  alu_op_e               op_q;
  logic                  sgn_q, err_q, gnt_q;
  logic [CW-1:0]         cnt_q;

  logic [1:0] arb_req, arb_grant, rsp_valid;
  logic       arb_idx, alu_valid, alu_rr, timeout;

  assign arb_req = (state_q == ST_IDLE) ? i_req_valid : 2'b00;
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .accept    (|arb_grant),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    alu_valid = 1'b0;
    alu_rr    = 1'b0;
    rsp_valid = 2'b00;
    case (state_q)
      ST_IDLE: begin
        // keep draining the ALU so a result from a timed-out operation is dropped here
        alu_rr = 1'b1;
        if (|arb_grant) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        alu_valid = 1'b1;
        if (i_alu_input_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        alu_rr = 1'b1;
        if (i_alu_result_valid || timeout) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        if (i_rsp_ready[gnt_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      sgn_q   <= 1'b0;
      gnt_q   <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (|arb_grant) begin
            a_q   <= i_req_a[arb_idx];
            b_q   <= i_req_b[arb_idx];
            op_q  <= alu_op_e'(i_req_op[arb_idx]);
            sgn_q <= i_req_signed[arb_idx];
            gnt_q <= arb_idx;
          end
        end
        ST_ISSUE: begin
          if (i_alu_input_ready) cnt_q <= '0;
        end
        ST_WAIT: begin
          // a result landing on the timeout cycle still takes priority
          if (i_alu_result_valid) begin
            res_q <= i_alu_result;
            err_q <= i_alu_error;
          end else if (timeout) begin
            res_q <= '0;
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // outputs are forced quiet for the whole cycle in which reset is asserted
  assign o_req_ready        = rst ? 2'b00 : arb_grant;
  assign o_rsp_valid        = rst ? 2'b00 : rsp_valid;
  assign o_rsp_result       = rst ? '0 : res_q;
  assign o_rsp_error        = ~rst & err_q;
  assign o_alu_input_valid  = ~rst & alu_valid;
  assign o_alu_result_ready = ~rst & alu_rr;
  assign o_alu_input_a      = a_q;
  assign o_alu_input_b      = b_q;
  assign o_alu_input_op     = op_q;
  assign o_alu_input_signed = sgn_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;

  localparam int W = 16;
  localparam int T = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0][W-1:0]   req_a, req_b;
  logic [1:0][1:0]     req_op;
  logic [1:0]          req_signed, req_valid, req_ready;
  logic [W-1:0]        rsp_result;
  logic                rsp_error;
  logic [1:0]          rsp_valid, rsp_ready;
  logic [W-1:0]        alu_a, alu_b, alu_result;
  logic [1:0]          alu_op;
  logic                alu_signed, alu_valid, alu_in_ready;
  logic                alu_error, alu_res_valid, alu_res_ready;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_req_a            (req_a),
    .i_req_b            (req_b),
    .i_req_op           (req_op),
    .i_req_signed       (req_signed),
    .i_req_valid        (req_valid),
    .o_req_ready        (req_ready),
    .o_rsp_result       (rsp_result),
    .o_rsp_error        (rsp_error),
    .o_rsp_valid        (rsp_valid),
    .i_rsp_ready        (rsp_ready),
    .o_alu_input_a      (alu_a),
    .o_alu_input_b      (alu_b),
    .o_alu_input_op     (alu_op),
    .o_alu_input_signed (alu_signed),
    .o_alu_input_valid  (alu_valid),
    .i_alu_input_ready  (alu_in_ready),
    .i_alu_result       (alu_result),
    .i_alu_error        (alu_error),
    .i_alu_result_valid (alu_res_valid),
    .o_alu_result_ready (alu_res_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [1:0] op, input logic s);
    logic [W-1:0] r;
    logic         e;
    e = 1'b0;
    case (op)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: r = W'(a * b);
      default: begin
        if (b == '0) begin
          r = '0;
          e = 1'b1;
        end else if (s) begin
          r = W'($signed(a) / $signed(b));
        end else begin
          r = a / b;
        end
      end
    endcase
    return {e, r};
  endfunction

  // both asking: the one not served last time wins
  function automatic logic [1:0] pick(input logic [1:0] v, input int last_served);
    if (v == 2'b11) return (last_served == 0) ? 2'b10 : 2'b01;
    return v;
  endfunction

  // model of the single outstanding operation: 0 free, 1 to ALU, 2 computing, 3 replying
  int           stage = 0;
  int           waited = 0;
  int           owner = 0;
  int           last = 1;
  logic [W-1:0] c_a, c_b, h_res;
  logic [1:0]   c_op;
  logic         c_s, h_err, h_to;
  logic [1:0]   acc_req;
  logic         acc_alu;

  initial forever begin
    logic [1:0] w, e_rr, e_rv;
    logic       e_av, e_ar;
    logic [W:0] ex;
    @(negedge clk);
    e_rr = 2'b00; e_rv = 2'b00; e_av = 1'b0; e_ar = 1'b0;
    acc_req = 2'b00; acc_alu = 1'b0;
    w = pick(req_valid, last);
    if (!rst) begin
      case (stage)
        0: begin e_rr = w; e_ar = 1'b1; end
        1: e_av = 1'b1;
        2: e_ar = 1'b1;
        default: e_rv = (owner == 0) ? 2'b01 : 2'b10;
      endcase
    end
    chk("req_ready", 32'(req_ready), 32'(e_rr));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("alu_input_valid", 32'(alu_valid), 32'(e_av));
    chk("alu_result_ready", 32'(alu_res_ready), 32'(e_ar));
    if (e_av) begin
      chk("alu_a", 32'(alu_a), 32'(c_a));
      chk("alu_b", 32'(alu_b), 32'(c_b));
      chk("alu_op", 32'(alu_op), 32'(c_op));
      chk("alu_signed", 32'(alu_signed), 32'(c_s));
    end
    if (e_rv != 2'b00) begin
      chk("rsp_result", 32'(rsp_result), 32'(h_res));
      chk("rsp_error", 32'(rsp_error), 32'(h_err));
    end
    if (rst) begin
      chk("rst_rsp_result", 32'(rsp_result), 0);
      chk("rst_rsp_error", 32'(rsp_error), 0);
      stage = 0;
      last  = 1;
    end else begin
      case (stage)
        0: if (w != 2'b00) begin
          owner = w[1] ? 1 : 0;
          last  = owner;
          c_a = req_a[owner]; c_b = req_b[owner]; c_op = req_op[owner]; c_s = req_signed[owner];
          acc_req = w;
          stage = 1;
        end
        1: if (alu_in_ready) begin
          acc_alu = 1'b1;
          waited  = 0;
          stage   = 2;
        end
        2: begin
          waited++;
          if (alu_res_valid) begin
            h_res = alu_result; h_err = alu_error; h_to = 1'b0; stage = 3;
          end else if (waited == T) begin
            h_res = '0; h_err = 1'b1; h_to = 1'b1; stage = 3;
          end
        end
        default: if (rsp_ready[owner]) begin
          if (!h_to) begin
            ex = alu_fn(c_a, c_b, c_op, c_s);
            chk("sb_result", 32'(rsp_result), 32'(ex[W-1:0]));
            chk("sb_error", 32'(rsp_error), 32'(ex[W]));
          end
          stage = 0;
        end
      endcase
    end
  end

  int unsigned p_new, p_drop, p_rsp, p_alu, dmax;
  int          left [2];
  logic        pend;
  int unsigned pcnt;
  logic [W:0]  pval;
  int          glog [$];
  int          exp_order [6] = '{0, 1, 0, 1, 0, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic agents();
    for (int i = 0; i < 2; i++) begin
      if (acc_req[i]) req_valid[i] = 1'b0;
      else if (req_valid[i] && $urandom_range(99) < p_drop) req_valid[i] = 1'b0;
      if (!req_valid[i] && left[i] > 0 && $urandom_range(99) < p_new) begin
        req_a[i]      = W'($urandom);
        req_b[i]      = ($urandom_range(3) == 0) ? '0 : W'($urandom);
        req_op[i]     = 2'($urandom);
        req_signed[i] = 1'($urandom);
        req_valid[i]  = 1'b1;
        left[i]--;
      end
      rsp_ready[i] = ($urandom_range(99) < p_rsp);
    end
    alu_in_ready  = ($urandom_range(99) < p_alu);
    alu_res_valid = 1'b0;
    alu_error     = 1'b0;
    if (acc_alu) begin
      pend = 1'b1;
      pcnt = $urandom_range(dmax);
      pval = alu_fn(c_a, c_b, c_op, c_s);
    end
    if (pend) begin
      if (pcnt == 0) begin
        alu_res_valid = 1'b1;
        alu_result    = pval[W-1:0];
        alu_error     = pval[W];
        pend          = 1'b0;
      end else begin
        pcnt--;
      end
    end
  endtask

  task automatic agent_cycle();
    tick();
    agents();
    @(negedge clk);
    if ((req_ready & req_valid) != 2'b00) glog.push_back(req_ready[1] ? 1 : 0);
  endtask

  initial begin
    rst = 1'b1;
    req_a = '0; req_b = '0; req_op = '0; req_signed = '0; req_valid = '0;
    rsp_ready = '0; alu_in_ready = 1'b0; alu_result = '0; alu_error = 1'b0; alu_res_valid = 1'b0;
    pend = 1'b0; pcnt = 0; pval = '0;

    tick(); tick();
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_alu_valid", 32'(alu_valid), 0);
    chk("reset_alu_rr", 32'(alu_res_ready), 0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("idle_alu_rr", 32'(alu_res_ready), 1);

    // single ADD 5+7, response three cycles after transfer; non-owner ready ignored
    tick(); req_valid = 2'b01; req_a[0] = 16'd5; req_b[0] = 16'd7; req_op[0] = 2'd0; alu_in_ready = 1'b1;
    @(negedge clk); chk("single_grant", 32'(req_ready), 1);
    tick(); req_valid = 2'b00;
    @(negedge clk); chk("single_alu_valid", 32'(alu_valid), 1); chk("single_alu_a", 32'(alu_a), 5);
    tick(); alu_res_valid = 1'b1; alu_result = 16'd12;
    @(negedge clk); chk("single_rsp_early", 32'(rsp_valid), 0);
    tick(); alu_res_valid = 1'b0; rsp_ready = 2'b10;
    @(negedge clk);
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_result", 32'(rsp_result), 12);
    chk("single_error", 32'(rsp_error), 0);
    tick();
    @(negedge clk); chk("non_owner_ready_ignored", 32'(rsp_valid), 1);
    tick(); rsp_ready = 2'b01;
    @(negedge clk);
    tick(); rsp_ready = 2'b00;
    @(negedge clk); chk("single_done", 32'(rsp_valid), 0);

    // backpressure: SUB 20-3 with ALU stalled, requester 0 waiting with DIV 9/0
    tick(); req_valid = 2'b10; req_a[1] = 16'd20; req_b[1] = 16'd3; req_op[1] = 2'd1; alu_in_ready = 1'b0;
    @(negedge clk); chk("bp_grant", 32'(req_ready), 2);
    for (int k = 0; k < 5; k++) begin
      tick(); req_valid = 2'b01; req_a[0] = 16'd9; req_b[0] = 16'd0; req_op[0] = 2'd3;
      @(negedge clk);
      chk("bp_alu_hold_a", 32'(alu_a), 20);
      chk("bp_alu_hold_op", 32'(alu_op), 1);
      chk("bp_no_grant", 32'(req_ready), 0);
    end
    tick(); alu_in_ready = 1'b1;
    @(negedge clk); chk("bp_alu_valid", 32'(alu_valid), 1);
    tick(); alu_in_ready = 1'b0; alu_res_valid = 1'b1; alu_result = 16'd17;
    @(negedge clk);
    tick(); alu_res_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_rsp_hold_valid", 32'(rsp_valid), 2);
      chk("bp_rsp_hold_result", 32'(rsp_result), 17);
      chk("bp_rsp_no_grant", 32'(req_ready), 0);
      tick();
    end
    rsp_ready = 2'b10;
    @(negedge clk);
    tick(); rsp_ready = 2'b00;
    @(negedge clk); chk("div_grant", 32'(req_ready), 1);

    // divide by zero error passes through
    tick(); req_valid = 2'b00; alu_in_ready = 1'b1;
    @(negedge clk); chk("div_alu_op", 32'(alu_op), 3);
    tick(); alu_in_ready = 1'b0; alu_res_valid = 1'b1; alu_result = '0; alu_error = 1'b1;
    @(negedge clk);
    tick(); alu_res_valid = 1'b0; alu_error = 1'b0; rsp_ready = 2'b01;
    @(negedge clk);
    chk("div_rsp_valid", 32'(rsp_valid), 1);
    chk("div_rsp_error", 32'(rsp_error), 1);
    tick(); rsp_ready = 2'b00;
    @(negedge clk);

    // timeout after T waiting cycles, then a late result is dropped
    tick(); req_valid = 2'b10; req_a[1] = 16'd1; req_b[1] = 16'd2; req_op[1] = 2'd0; alu_in_ready = 1'b1;
    @(negedge clk); chk("to_grant", 32'(req_ready), 2);
    tick(); req_valid = 2'b00;
    @(negedge clk);
    tick(); alu_in_ready = 1'b0;
    for (int k = 0; k < T; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      chk("to_waiting", 32'(rsp_valid), 0);
      chk("to_alu_rr", 32'(alu_res_ready), 1);
    end
    tick();
    @(negedge clk);
    chk("to_rsp_valid", 32'(rsp_valid), 2);
    chk("to_rsp_result", 32'(rsp_result), 0);
    chk("to_rsp_error", 32'(rsp_error), 1);
    tick(); rsp_ready = 2'b10;
    @(negedge clk);
    tick(); rsp_ready = 2'b00;
    @(negedge clk);
    tick(); alu_res_valid = 1'b1; alu_result = 16'd3;
    @(negedge clk);
    chk("stale_no_rsp", 32'(rsp_valid), 0);
    chk("stale_alu_rr", 32'(alu_res_ready), 1);
    tick(); alu_res_valid = 1'b0;
    @(negedge clk); chk("stale_no_rsp_after", 32'(rsp_valid), 0);

    // reset while waiting on the ALU
    tick(); req_valid = 2'b01; req_a[0] = 16'd4; req_b[0] = 16'd4; req_op[0] = 2'd0; alu_in_ready = 1'b1;
    @(negedge clk);
    tick(); req_valid = 2'b00;
    @(negedge clk);
    tick(); alu_in_ready = 1'b0;
    @(negedge clk);
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_alu_rr", 32'(alu_res_ready), 0);
    chk("rst_wait_rsp_valid", 32'(rsp_valid), 0);
    tick(); rst = 1'b0; req_valid = 2'b11; req_a[1] = 16'd6; req_b[1] = 16'd2; req_op[1] = 2'd2;
    @(negedge clk);
    chk("post_rst_alu_rr", 32'(alu_res_ready), 1);
    chk("post_rst_alu_a", 32'(alu_a), 0);
    chk("post_rst_ptr", 32'(req_ready), 1);
    glog.delete();
    if ((req_ready & req_valid) != 2'b00) glog.push_back(req_ready[1] ? 1 : 0);

    // contention: three back-to-back requests each
    p_new = 100; p_drop = 0; p_rsp = 100; p_alu = 100; dmax = 0;
    left[0] = 2; left[1] = 2;
    for (int k = 0; k < 200 && glog.size() < 6; k++) agent_cycle();
    for (int k = 0; k < 10; k++) agent_cycle();
    chk("grant_count", 32'(glog.size()), 6);
    for (int k = 0; k < 6 && k < glog.size(); k++) chk("grant_order", 32'(glog[k]), 32'(exp_order[k]));

    // randomized traffic with stalls, drops and occasional timeouts
    p_new = 60; p_drop = 10; p_rsp = 60; p_alu = 60; dmax = 6;
    left[0] = 100000; left[1] = 100000;
    for (int k = 0; k < 3000; k++) agent_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
